// File: rtl/mem_access_unit.sv
// Load/store access unit between the MEM stage and a single-beat data bus.
// Builds byte enables and lane-aligned store data, splits misaligned
// accesses into two bus beats (or rejects them when splitting is disabled),
// and right-justifies and extends load data. One request in flight at a time.
module mem_access_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, REQ0, RD0, REQ1, RD1, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic [OFFW-1:0]     off_q, off_d;
    logic                mis_q, mis_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [2*NB-1:0]     mask_q, mask_d;
    logic [2*DATA_W-1:0] wsh_q, wsh_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [OFFW-1:0]     req_off;
    int                  req_bytes;
    logic                req_mis;
    logic                req_bad;
    logic [2*DATA_W-1:0] ld_pair;
    logic [DATA_W-1:0]   ld_low;
    logic [DATA_W-1:0]   ld_result;

    // Keep the low 8<<sz bits of v and fill the rest with zeros or the sign bit.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] v,
                                                      input logic [1:0]        sz,
                                                      input logic              sgn);
        logic signed [DATA_W-1:0] s;
        int nbits;
        nbits = 8 << sz;
        if (nbits > DATA_W) nbits = DATA_W;
        s = v;
        s = s <<< (DATA_W - nbits);
        if (sgn) s = s >>> (DATA_W - nbits);
        else     s = s >> (DATA_W - nbits);
        return s;
    endfunction

    // Decode the incoming request: lane offset, access length, misalignment, legality.
    always_comb begin
        req_off   = req_addr[OFFW-1:0];
        req_bytes = 1 << req_size;
        req_mis   = (int'(req_off) + req_bytes) > NB;
        req_bad   = (req_bytes > NB) || (req_mis && (SPLIT_EN == 0));
    end

    // Align returned read data: the second beat (if any) sits above the first.
    always_comb begin
        if (state_q == RD1) ld_pair = {bus_rdata, rdata0_q};
        else                ld_pair = {{DATA_W{1'b0}}, bus_rdata};
        ld_low    = DATA_W'(ld_pair >> {off_q, 3'b000});
        ld_result = extend_load(ld_low, size_q, sgn_q);
    end

    // Next-state logic: sequence the beats and build the response on entry to RESP.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        mis_d       = mis_q;
        base_d      = base_q;
        mask_d      = mask_q;
        wsh_d       = wsh_q;
        rdata0_d    = rdata0_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    size_d = req_size;
                    sgn_d  = req_signed;
                    off_d  = req_off;
                    mis_d  = req_mis;
                    base_d = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                    // Enables and data are formed across two bus words so the
                    // upper half directly becomes the second beat.
                    mask_d = (2*NB)'((1 << req_bytes) - 1) << req_off;
                    wsh_d  = {{DATA_W{1'b0}}, req_wdata} << {req_off, 3'b000};
                    if (req_bad) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = REQ0;
                    end
                end
            end
            REQ0: begin
                if (bus_ready) begin
                    if (!we_q) begin
                        state_d = RD0;
                    end else if (mis_q) begin
                        state_d = REQ1;
                    end else begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                    end
                end
            end
            REQ1: begin
                if (bus_ready) begin
                    if (!we_q) begin
                        state_d = RD1;
                    end else begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                    end
                end
            end
            RD0: begin
                if (bus_rvalid) begin
                    rdata0_d = bus_rdata;
                    if (mis_q) begin
                        state_d = REQ1;
                    end else begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = ld_result;
                    end
                end
            end
            RD1: begin
                if (bus_rvalid) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = ld_result;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            off_q       <= '0;
            mis_q       <= 1'b0;
            base_q      <= '0;
            mask_q      <= '0;
            wsh_q       <= '0;
            rdata0_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            mis_q       <= mis_d;
            base_q      <= base_d;
            mask_q      <= mask_d;
            wsh_q       <= wsh_d;
            rdata0_q    <= rdata0_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Output decode: bus fields are driven only while a beat is being offered.
    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        if (state_q == REQ0) begin
            bus_valid = 1'b1;
            bus_we    = we_q;
            bus_addr  = base_q;
            bus_be    = mask_q[NB-1:0];
            bus_wdata = wsh_q[DATA_W-1:0];
        end else if (state_q == REQ1) begin
            bus_valid = 1'b1;
            bus_we    = we_q;
            bus_addr  = base_q + ADDR_W'(NB);
            bus_be    = mask_q[2*NB-1:NB];
            bus_wdata = wsh_q[2*DATA_W-1:DATA_W];
        end
        rsp_valid = (state_q == RESP);
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (DATA_W=32). A byte-level model predicts every
// bus beat and response; a negedge monitor checks the DUT against it, and
// directed vectors pin the model with hand-computed values. A second
// instance with splitting disabled covers misalignment rejection.
module tb_mem_access_unit;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        s0_req_valid, s0_req_ready, s0_req_we, s0_req_signed;
    logic [1:0]  s0_req_size;
    logic [31:0] s0_req_addr, s0_req_wdata;
    logic        s0_bus_valid, s0_bus_ready, s0_bus_we, s0_bus_rvalid;
    logic [31:0] s0_bus_addr, s0_bus_wdata, s0_bus_rdata;
    logic [3:0]  s0_bus_be;
    logic        s0_rsp_valid, s0_rsp_err;
    logic [31:0] s0_rsp_rdata;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(0)) dut_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(s0_req_valid), .req_ready(s0_req_ready), .req_we(s0_req_we),
        .req_size(s0_req_size), .req_signed(s0_req_signed), .req_addr(s0_req_addr),
        .req_wdata(s0_req_wdata),
        .bus_valid(s0_bus_valid), .bus_ready(s0_bus_ready), .bus_we(s0_bus_we),
        .bus_addr(s0_bus_addr), .bus_be(s0_bus_be), .bus_wdata(s0_bus_wdata),
        .bus_rvalid(s0_bus_rvalid), .bus_rdata(s0_bus_rdata),
        .rsp_valid(s0_rsp_valid), .rsp_rdata(s0_rsp_rdata), .rsp_err(s0_rsp_err)
    );

    int tests;
    int fails;
    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Model expectations for the transaction in progress.
    logic        exp_we;
    int          nbeats;
    logic [31:0] eb_addr [2];
    logic [31:0] eb_wd   [2];
    logic [3:0]  eb_be   [2];
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          bi;
    int          bi_base;
    int          mon_idx;
    bit          mon_en;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic miss(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Byte-by-byte model: each accessed byte lands in lane (addr+k)%4 of
    // beat (off+k)/4; loads gather those bytes back and extend.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd0, input logic [31:0] rd1, input bit split);
        int off, bytes, p, b, lane;
        logic [31:0] res;
        off        = int'(addr[1:0]);
        bytes      = 1 << size;
        exp_we     = we;
        nbeats     = 0;
        eb_be[0]   = '0;
        eb_be[1]   = '0;
        eb_wd[0]   = '0;
        eb_wd[1]   = '0;
        eb_addr[0] = addr - 32'(off);
        eb_addr[1] = addr - 32'(off) + 32'd4;
        exp_rdata  = '0;
        exp_err    = 1'b0;
        res        = '0;
        if (bytes > NB || (off + bytes > NB && !split)) begin
            exp_err = 1'b1;
        end else begin
            for (int k = 0; k < bytes; k++) begin
                p    = off + k;
                b    = p / NB;
                lane = p % NB;
                eb_be[b][lane] = 1'b1;
                if (we) eb_wd[b][8*lane +: 8] = wdata[8*k +: 8];
                else    res[8*k +: 8] = (b == 0) ? rd0[8*lane +: 8] : rd1[8*lane +: 8];
                if (b + 1 > nbeats) nbeats = b + 1;
            end
            if (!we && sgn && res[8*bytes-1])
                for (int k = 8*bytes; k < 32; k++) res[k] = 1'b1;
            exp_rdata = we ? 32'd0 : res;
        end
    endtask

    // Compare process: every offered beat and every response against the model.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            mon_idx = bi - bi_base;
            if (bus_valid) begin
                if (mon_idx >= nbeats) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: bus_valid with addr 0x%0h, required no beat", bus_addr);
                end else begin
                    chk("bus_addr", 64'(bus_addr), 64'(eb_addr[mon_idx]));
                    chk("bus_be", 64'(bus_be), 64'(eb_be[mon_idx]));
                    chk("bus_we", 64'(bus_we), 64'(exp_we));
                    if (exp_we) chk("bus_wdata", 64'(bus_wdata), 64'(eb_wd[mon_idx]));
                    if (bus_ready) bi <= bi + 1;
                end
            end
            if (rsp_valid) begin
                chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
                chk("rsp_err", 64'(rsp_err), 64'(exp_err));
                chk("rsp_beats_done", 64'(mon_idx), 64'(nbeats));
            end
        end
    end

    // One complete access on the splitting instance, acting as the bus slave.
    task automatic run(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rd0, input logic [31:0] rd1,
                       input int stall, input int rlat);
        int n, acc, exp_lat;
        bit ok;
        model(we, size, sgn, addr, wdata, rd0, rd1, 1'b1);
        bi_base = bi;
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        acc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 32'h5A5A5A5A;
        ok = 1'b1;
        for (int b = 0; b < nbeats && ok; b++) begin
            n = 0;
            while (!bus_valid && n < 20) begin @(posedge clk); #1; n++; end
            if (!bus_valid) begin
                miss({tag, "_beat"});
                ok = 1'b0;
            end else begin
                repeat (stall) begin @(posedge clk); #1; end
                bus_ready = 1'b1;
                @(posedge clk); #1;
                bus_ready = 1'b0;
                if (!we) begin
                    repeat (rlat) begin @(posedge clk); #1; end
                    bus_rvalid = 1'b1;
                    bus_rdata  = (b == 0) ? rd0 : rd1;
                    @(posedge clk); #1;
                    bus_rvalid = 1'b0;
                    bus_rdata  = '0;
                end
            end
        end
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) begin
            miss({tag, "_rsp"});
        end else begin
            if (stall == 0 && rlat == 0) begin
                exp_lat = exp_err ? 1 : (we ? 1 + nbeats : 1 + 2*nbeats);
                chk({tag, "_latency"}, 64'(cyc - acc), 64'(exp_lat));
            end
            @(posedge clk); #1;
            chk({tag, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
            chk({tag, "_idle_after"}, 64'(req_ready), 64'd1);
            chk({tag, "_rdata_hold"}, 64'(rsp_rdata), 64'(exp_rdata));
        end
    endtask

    // Rejected access on the non-splitting instance: one error pulse, no beat.
    task automatic nosplit_err(input string tag, input logic [1:0] size, input logic [31:0] addr);
        int pulses, beats;
        chk({tag, "_req_ready"}, 64'(s0_req_ready), 64'd1);
        s0_req_valid  = 1'b1;
        s0_req_we     = 1'b0;
        s0_req_size   = size;
        s0_req_signed = 1'b1;
        s0_req_addr   = addr;
        @(posedge clk); #1;
        s0_req_valid = 1'b0;
        pulses = 0;
        beats  = 0;
        repeat (6) begin
            if (s0_bus_valid) beats++;
            if (s0_rsp_valid) begin
                pulses++;
                chk({tag, "_err"}, 64'(s0_rsp_err), 64'd1);
                chk({tag, "_rdata"}, 64'(s0_rsp_rdata), 64'd0);
            end
            @(posedge clk); #1;
        end
        chk({tag, "_rsp_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_bus_beats"}, 64'(beats), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        s0_req_valid = 1'b0; s0_req_we = 1'b0; s0_req_size = '0; s0_req_signed = 1'b0;
        s0_req_addr = '0; s0_req_wdata = '0;
        s0_bus_ready = 1'b1; s0_bus_rvalid = 1'b0; s0_bus_rdata = '0;
        mon_en = 1'b0;

        #2;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_bus_valid", 64'(bus_valid), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_bus_fields", 64'({bus_addr, bus_be, bus_wdata, bus_we}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        run("sb_1002", 1'b1, 2'd0, 1'b0, 32'h1002, 32'h000000AB, '0, '0, 0, 0);
        chk("pin_sb_beats", 64'(nbeats), 64'd1);
        chk("pin_sb_addr", 64'(eb_addr[0]), 64'h1000);
        chk("pin_sb_be", 64'(eb_be[0]), 64'h4);
        chk("pin_sb_wdata", 64'(eb_wd[0]), 64'h00AB0000);

        run("lh_signed", 1'b0, 2'd1, 1'b1, 32'h1002, '0, 32'h80011234, '0, 0, 0);
        chk("pin_lh_signed", 64'(exp_rdata), 64'hFFFF8001);
        run("lh_unsigned", 1'b0, 2'd1, 1'b0, 32'h1002, '0, 32'h80011234, '0, 0, 0);
        chk("pin_lh_unsigned", 64'(exp_rdata), 64'h00008001);

        run("sw_split", 1'b1, 2'd2, 1'b0, 32'h1003, 32'h11223344, '0, '0, 0, 0);
        chk("pin_sw_beats", 64'(nbeats), 64'd2);
        chk("pin_sw_b0", 64'({eb_addr[0], eb_be[0]}), 64'({32'h1000, 4'b1000}));
        chk("pin_sw_b0_wdata", 64'(eb_wd[0]), 64'h44000000);
        chk("pin_sw_b1", 64'({eb_addr[1], eb_be[1]}), 64'({32'h1004, 4'b0111}));
        chk("pin_sw_b1_wdata", 64'(eb_wd[1]), 64'h00112233);

        run("lw_split", 1'b0, 2'd2, 1'b0, 32'h1001, '0, 32'hDDCCBBAA, 32'h44332211, 0, 0);
        chk("pin_lw_split", 64'(exp_rdata), 64'h11DDCCBB);

        run("size3_err", 1'b0, 2'd3, 1'b0, 32'h1000, '0, '0, '0, 0, 0);
        chk("pin_size3", 64'({exp_err, exp_rdata}), 64'({1'b1, 32'h0}));

        run("sw_wrap", 1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hCAFEBABE, '0, '0, 0, 0);
        chk("pin_wrap_b1_addr", 64'(eb_addr[1]), 64'h0);

        run("sh_stall", 1'b1, 2'd1, 1'b0, 32'h1006, 32'h0000BEEF, '0, '0, 3, 0);
        run("lb_stall", 1'b0, 2'd0, 1'b1, 32'h1003, '0, 32'h80000000, '0, 3, 2);
        chk("pin_lb_signed", 64'(exp_rdata), 64'hFFFFFF80);
        run("sh_split", 1'b1, 2'd1, 1'b0, 32'h1007, 32'h0000BEEF, '0, '0, 0, 0);
        chk("pin_sh_split_wd", 64'({eb_wd[1], eb_wd[0]}), 64'h000000BE_EF000000);
        run("lhu_split", 1'b0, 2'd1, 1'b0, 32'h1007, '0, 32'h7F000000, 32'h000000C3, 1, 1);
        chk("pin_lhu_split", 64'(exp_rdata), 64'h0000C37F);
        run("lw_lat", 1'b0, 2'd2, 1'b1, 32'h1008, '0, 32'h89ABCDEF, '0, 0, 1);

        // Reset while waiting for read data: no response, stray read data ignored.
        mon_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h2000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!bus_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus_valid) miss("rst_mid_beat");
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mid_bus_valid", 64'(bus_valid), 64'd0);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_idle", 64'(req_ready), 64'd1);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEADBEEF;
        repeat (2) begin
            @(posedge clk); #1;
            chk("stray_rvalid_rsp", 64'(rsp_valid), 64'd0);
            chk("stray_rvalid_bus", 64'(bus_valid), 64'd0);
        end
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        repeat (2) begin @(posedge clk); #1; end
        chk("stray_rvalid_idle", 64'(req_ready), 64'd1);
        mon_en = 1'b1;

        run("after_rst", 1'b0, 2'd0, 1'b0, 32'h3001, '0, 32'h0000A500, '0, 0, 0);
        chk("pin_after_rst", 64'(exp_rdata), 64'h000000A5);

        nosplit_err("ns_lw_1002", 2'd2, 32'h1002);
        nosplit_err("ns_size3", 2'd3, 32'h1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
